// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- writeback stage + 32x32 integer register file
//
// Purpose: selects the writeback value (load data or ALU result), commits it
// to the register file, serves two decode-stage read ports with same-cycle
// write-through bypass, and counts committed register writes.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high
//   ReadDataW    in  32   load data from MEM/WB
//   ALUResultW   in  32   ALU result from MEM/WB
//   RdW          in   5   destination register index
//   RegWriteW    in   1   register write enable
//   MemToRegW    in   1   1 = ReadDataW, 0 = ALUResultW
//   Rs1D, Rs2D   in   5   decode-stage source indices
//   RD1D, RD2D   out 32   decode-stage read data
//   ResultW      out 32   selected writeback value (to EX forwarding)
//   RetireCount  out 64   committed register writes, wraps silently
// ---------------------------------------------------------------------------

// One read port: x0 hardwired, bypass from the in-flight write, zero in reset.
module wb_regfile_rdport (
  input  logic        reset_i,
  input  logic [4:0]  rs_i,
  input  logic [31:0] stored_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] data_o
);
  always_comb begin
    data_o = stored_i;
    if (reset_i || rs_i == 5'd0)
      data_o = '0;
    else if (wr_en_i && wr_addr_i == rs_i)
      data_o = wr_data_i;
  end
endmodule

module wb_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ReadDataW,
  input  logic [31:0] ALUResultW,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic        MemToRegW,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ResultW,
  output logic [63:0] RetireCount
);
  localparam int NUM_RD = 2;

  logic [31:0] regs_q [32];
  logic [63:0] retire_q, retire_d;
  logic        wr_en;

  logic [NUM_RD-1:0][4:0]  rs;
  logic [NUM_RD-1:0][31:0] rd_data;

  assign ResultW = MemToRegW ? ReadDataW : ALUResultW;

  // Writes to x0 are dropped here so the count and bypass agree with storage.
  assign wr_en = RegWriteW && (RdW != 5'd0);

  assign retire_d = wr_en ? retire_q + 64'd1 : retire_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      retire_q <= '0;
    end else begin
      if (wr_en) regs_q[RdW] <= ResultW;
      retire_q <= retire_d;
    end
  end

  assign rs = {Rs2D, Rs1D};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_regfile_rdport u_rdport (
      .reset_i   (reset),
      .rs_i      (rs[p]),
      .stored_i  (regs_q[rs[p]]),
      .wr_en_i   (wr_en),
      .wr_addr_i (RdW),
      .wr_data_i (ResultW),
      .data_o    (rd_data[p])
    );
  end

  assign RD1D        = rd_data[0];
  assign RD2D        = rd_data[1];
  assign RetireCount = retire_q;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ReadDataW = '0, ALUResultW = '0;
  logic [4:0]  RdW = '0, Rs1D = '0, Rs2D = '0;
  logic        RegWriteW = 1'b0, MemToRegW = 1'b0;
  logic [31:0] RD1D, RD2D, ResultW;
  logic [63:0] RetireCount;

  wb_regfile dut (
    .clk(clk), .reset(reset), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .RdW(RdW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
    .ResultW(ResultW), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1, e2, eres;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  logic [63:0] mcnt;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_res();
    return MemToRegW ? ReadDataW : ALUResultW;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] rs);
    if (reset || rs == 5'd0) return '0;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return m_res();
    return mdl[rs];
  endfunction

  // Drive one writeback/read pattern and push what the outputs must be.
  task automatic drive(input string tag, input logic we, input logic [4:0] rd,
                       input logic m2r, input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    RegWriteW = we; RdW = rd; MemToRegW = m2r; ReadDataW = rdat; ALUResultW = alu;
    Rs1D = r1; Rs2D = r2;
    e.tag = tag; e.e1 = m_rd(r1); e.e2 = m_rd(r2); e.eres = m_res();
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_rd1"}, {32'd0, RD1D}, {32'd0, e.e1});
    chk({e.tag, "_rd2"}, {32'd0, RD2D}, {32'd0, e.e2});
    chk({e.tag, "_res"}, {32'd0, ResultW}, {32'd0, e.eres});
  endtask

  // Clock edge; the model commits what the DUT should have committed.
  task automatic step();
    @(posedge clk);
    if (!reset && RegWriteW && RdW != 5'd0) begin
      mdl[RdW] = m_res();
      mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle_read(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    drive(tag, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, r1, r2);
    sample();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = '0;

    // Reset state; ResultW stays a pure mux during reset.
    #2;
    chk("rst_cnt", RetireCount, 64'd0);
    drive("rst_mux", 1'b1, 5'd4, 1'b1, 32'hCAFE_F00D, 32'h1111_1111, 5'd4, 5'd0);
    sample();
    @(negedge clk);
    reset = 1'b0;

    // Simple write then read back.
    drive("w5", 1'b1, 5'd5, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd1);
    sample();
    step();
    idle_read("r5", 5'd5, 5'd0);
    chk("cnt_w5", RetireCount, mcnt);

    // x0 write ignored, not counted.
    drive("w0", 1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    sample();
    step();
    idle_read("r0", 5'd0, 5'd0);
    chk("cnt_w0", RetireCount, mcnt);

    // Load-data bypass to both ports on the same register.
    drive("byp7", 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd7, 5'd7);
    sample();
    step();
    idle_read("r7", 5'd7, 5'd7);

    // Disabled write leaves the register alone and shows no bypass.
    drive("w3", 1'b1, 5'd3, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd1, 5'd2);
    sample();
    step();
    drive("nw3", 1'b0, 5'd3, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3);
    sample();
    step();
    idle_read("r3", 5'd3, 5'd5);
    chk("cnt_w3", RetireCount, mcnt);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      drive("rnd", 1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom), 5'($urandom));
      sample();
      step();
      chk("cnt_rnd", RetireCount, mcnt);
    end

    // Fill x1..x31, then assert reset between edges.
    for (int i = 1; i < 32; i++) begin
      drive("fill", 1'b1, 5'(i), 1'b0, 32'h0, 32'h100 + 32'(i), 5'(i), 5'(32 - i));
      sample();
      step();
    end
    #2;
    RegWriteW = 1'b1; RdW = 5'd9; MemToRegW = 1'b0; ALUResultW = 32'h9999_9999;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = '0;
    #1;
    chk("arst_cnt", RetireCount, 64'd0);
    for (int i = 0; i < 32; i++) begin
      Rs1D = 5'(i); Rs2D = 5'(31 - i);
      #1;
      chk("arst_rd1", {32'd0, RD1D}, 64'd0);
      chk("arst_rd2", {32'd0, RD2D}, 64'd0);
    end
    step();  // the write held during reset must be lost
    reset = 1'b0;
    idle_read("lost9", 5'd9, 5'd31);
    chk("cnt_lost", RetireCount, 64'd0);
    drive("w1", 1'b1, 5'd1, 1'b0, 32'h0, 32'h1, 5'd2, 5'd0);
    sample();
    step();
    idle_read("r1", 5'd1, 5'd0);
    chk("cnt_w1", RetireCount, 64'd1);

    // Counter wrap from all-ones.
    force dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_q;
    mcnt = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("cnt_max", RetireCount, mcnt);
    drive("wwrap", 1'b1, 5'd2, 1'b0, 32'h0, 32'h2222, 5'd2, 5'd0);
    sample();
    step();
    chk("cnt_wrap", RetireCount, 64'd0);
    chk("cnt_wrap_m", RetireCount, mcnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
